rr_mux4_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 4-to-1, 2-bit-wide selection datapath.
- Four requesters each present a data word with a valid/ready style handshake (req/ack).
- The block picks one requester fairly, drives the mux select, and captures the selected word into a single-entry output register.
- The output register has its own valid/ready handshake toward the downstream consumer.
- Sustains one transfer per cycle when downstream is ready.

---
 rtl/rr_mux_pkg.sv | 35 +++
 rtl/mux4_dw.sv | 27 ++
 rtl/rr_mux4_arbiter.sv | 90 +++++++++
 tb/tb_rr_mux4_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared types and the round-robin search used by the 4-requester arbiter.
package rr_mux_pkg;

  localparam int NREQ = 4;
  localparam int IDXW = 2;

  typedef logic [NREQ-1:0] req_vec_t;

  // Output register occupancy
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ostate_t;

  typedef struct packed {
    logic            found;
    logic [IDXW-1:0] idx;
  } pick_t;

  // First active requester searching ptr+1, ptr+2, ptr+3, ptr (2-bit wrap)
  function automatic pick_t rr_pick(input req_vec_t req, input logic [IDXW-1:0] ptr);
    pick_t           res;
    logic [IDXW-1:0] cand;
    res = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ptr + IDXW'(k);
      if (!res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux4_dw.sv
// Combinational 4-to-1 word selector for the shared datapath.
module mux4_dw
  import rr_mux_pkg::*;
#(
  parameter int DW = 2
) (
  input  logic [IDXW-1:0] sel,
  input  logic [DW-1:0]   d0,
  input  logic [DW-1:0]   d1,
  input  logic [DW-1:0]   d2,
  input  logic [DW-1:0]   d3,
  output logic [DW-1:0]   y
);

  // Pick the word addressed by sel
  always_comb begin
    y = d0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      2'd3:    y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter feeding a single-entry output register with its own
// valid/ready handshake; one transfer per cycle when downstream is ready.
module rr_mux4_arbiter
  import rr_mux_pkg::*;
#(
  parameter int DW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  req_vec_t        req,
  input  logic [DW-1:0]   d0,
  input  logic [DW-1:0]   d1,
  input  logic [DW-1:0]   d2,
  input  logic [DW-1:0]   d3,
  output req_vec_t        ack,
  output logic [IDXW-1:0] sel,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  input  logic            out_ready
);

  ostate_t         state_p1;
  ostate_t         state_nxt;
  logic [DW-1:0]   data_p1;
  logic [IDXW-1:0] sel_p1;
  logic [IDXW-1:0] ptr_q;
  logic [DW-1:0]   mux_word;
  pick_t           pick;
  logic            load_en;
  logic            grant;

  // ---- stage 0: arbitration and word selection (combinational) ----
  // The register can take a word when empty or draining on this edge.
  assign pick    = rr_pick(req, ptr_q);
  assign load_en = (state_p1 == EMPTY) || out_ready;
  assign grant   = load_en && pick.found;

  mux4_dw #(
    .DW (DW)
  ) u_mux (
    .sel (pick.idx),
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .y   (mux_word)
  );

  // One-hot ack for the winner; suppressed while reset is asserted
  always_comb begin
    ack = '0;
    if (rst_n && grant) ack[pick.idx] = 1'b1;
  end

  // Occupancy next state: a grant always fills, a drain without grant empties
  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      EMPTY:   if (grant) state_nxt = FULL;
      FULL:    if (grant) state_nxt = FULL;
               else if (out_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // ---- stage 1: output register ----
  // Occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_p1 <= EMPTY;
    else        state_p1 <= state_nxt;
  end

  // Capture winner word and index; pointer moves only on a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      sel_p1  <= '0;
      ptr_q   <= 2'd3;
    end else if (grant) begin
      data_p1 <= mux_word;
      sel_p1  <= pick.idx;
      ptr_q   <= pick.idx;
    end
  end

  assign out_valid = (state_p1 == FULL);
  assign out_data  = data_p1;
  assign sel       = sel_p1;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Randomized and directed bench for rr_mux4_arbiter against a behavioural model.
module tb_rr_mux4_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] dv [4];
  logic [3:0] ack;
  logic [1:0] sel;
  logic       out_valid;
  logic [1:0] out_data;
  logic       out_ready;

  int errors;
  int checks;

  // behavioural model state
  int         m_ptr;
  bit         m_valid;
  logic [1:0] m_data;
  logic [1:0] m_sel;

  rr_mux4_arbiter #(.DW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .d0        (dv[0]),
    .d1        (dv[1]),
    .d2        (dv[2]),
    .d3        (dv[3]),
    .ack       (ack),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Winner index per the round-robin rule, or -1 when nothing is granted
  function automatic int model_winner();
    if (!rst_n) return -1;
    if (m_valid && !out_ready) return -1;
    for (int k = 1; k <= 4; k++) begin
      if (req[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ack();
    int w;
    w = model_winner();
    if (w < 0) return 4'b0000;
    return 4'(1 << w);
  endfunction

  task automatic model_reset();
    m_ptr   = 3;
    m_valid = 1'b0;
    m_data  = 2'b00;
    m_sel   = 2'b00;
  endtask

  // Advance one clock: update the model from the inputs at the edge
  task automatic tick();
    int w;
    w = model_winner();
    if (w >= 0) begin
      m_data  = dv[w];
      m_sel   = 2'(w);
      m_ptr   = w;
      m_valid = 1'b1;
    end else if (!m_valid || out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    req = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) dv[i] = 2'(i);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++;
    if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++;
    if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", sel); end
    checks++;
    if (out_data !== 2'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", out_data); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ack !== 4'b0001) begin errors++; $display("FAIL reset_first_ack: got %b want 0001", ack); end
    req = 4'b0000;
    #1;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0100;
    dv[2] = 2'b10;
    out_ready = 1'b1;
    #1;
    checks++;
    if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b want 0100", ack); end
    tick();
    req = 4'b0000;
    #1;
    checks++;
    if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_drop: got %b want 0000", ack); end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 2'b10 || sel !== 2'd2) begin
      errors++;
      $display("FAIL single_out: got v=%b d=%0d s=%0d want v=1 d=2 s=2", out_valid, out_data, sel);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int i = 0; i < 4; i++) dv[i] = 2'(i);
    req = 4'b1111;
    out_ready = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (ack !== exp_seq[c]) begin errors++; $display("FAIL rotation_ack[%0d]: got %b want %b", c, ack, exp_seq[c]); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 2'(c % 4) || sel !== 2'(c % 4)) begin
        errors++;
        $display("FAIL rotation_out[%0d]: got v=%b d=%0d s=%0d want v=1 d=%0d s=%0d",
                 c, out_valid, out_data, sel, c % 4, c % 4);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] hold_d;
    logic [1:0] hold_s;
    logic [3:0] e;
    hold_d = m_data;
    hold_s = m_sel;
    req = 4'b1111;
    out_ready = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (ack !== 4'b0000) begin errors++; $display("FAIL bp_ack[%0d]: got %b want 0000", c, ack); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== hold_d || sel !== hold_s) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%0d s=%0d want v=1 d=%0d s=%0d",
                 c, out_valid, out_data, sel, hold_d, hold_s);
      end
    end
    out_ready = 1'b1;
    #1;
    e = 4'(1 << ((hold_s + 1) % 4));
    checks++;
    if (ack !== e) begin errors++; $display("FAIL bp_release_ack: got %b want %b", ack, e); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || sel !== m_sel || out_data !== m_data) begin
      errors++;
      $display("FAIL bp_release_out: got v=%b d=%0d s=%0d want v=1 d=%0d s=%0d",
               out_valid, out_data, sel, m_data, m_sel);
    end
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) dv[i] = 2'(3 - i);
    req = 4'b0010;
    #1;
    tick();
    req = 4'b1001;
    #1;
    checks++;
    if (ack !== 4'b1000) begin errors++; $display("FAIL wrap_ack0: got %b want 1000", ack); end
    tick();
    checks++;
    if (sel !== 2'd3 || out_data !== 2'd0) begin errors++; $display("FAIL wrap_sel0: got s=%0d d=%0d want s=3 d=0", sel, out_data); end
    checks++;
    if (ack !== 4'b0001) begin errors++; $display("FAIL wrap_ack1: got %b want 0001", ack); end
    tick();
    checks++;
    if (sel !== 2'd0 || out_data !== 2'd3) begin errors++; $display("FAIL wrap_sel1: got s=%0d d=%0d want s=0 d=3", sel, out_data); end
    req = 4'b0000;
    #1;
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    req = 4'b0100;
    dv[2] = 2'b01;
    #1;
    tick();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || ack !== 4'b0000 || out_data !== 2'd0 || sel !== 2'd0) begin
      errors++;
      $display("FAIL areset_async: got v=%b a=%b d=%0d s=%0d want v=0 a=0000 d=0 s=0",
               out_valid, ack, out_data, sel);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req = 4'b1111;
    out_ready = 1'b1;
    #1;
    checks++;
    if (ack !== 4'b0001) begin errors++; $display("FAIL areset_ptr: got %b want 0001", ack); end
    tick();
    checks++;
    if (sel !== 2'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL areset_first: got s=%0d v=%b want s=0 v=1", sel, out_valid); end
  endtask

  task automatic test_random();
    logic [3:0] e;
    for (int c = 0; c < 300; c++) begin
      req = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) dv[i] = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      e = model_ack();
      checks++;
      if (ack !== e) begin errors++; $display("FAIL rand_ack[%0d]: got %b want %b", c, ack, e); end
      tick();
      checks++;
      if (out_valid !== m_valid || (m_valid && (out_data !== m_data || sel !== m_sel))) begin
        errors++;
        $display("FAIL rand_out[%0d]: got v=%b d=%0d s=%0d want v=%b d=%0d s=%0d",
                 c, out_valid, out_data, sel, m_valid, m_data, m_sel);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    req = 4'b0000;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) dv[i] = 2'b00;
    model_reset();
    #1;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_sparse_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
